// File: rtl/regex_memory_pkg.sv
// Shared types for the regex instruction memory: default geometry, word/address types, host-write record.
// The round-robin pointer width helper keeps a 1-bit pointer legal for single-core builds.
package regex_memory_pkg;

  localparam int DEF_MEMORY_WIDTH      = 16;
  localparam int DEF_MEMORY_ADDR_WIDTH = 11;

  typedef logic [DEF_MEMORY_ADDR_WIDTH-1:0] mem_addr_t;
  typedef logic [DEF_MEMORY_WIDTH-1:0]      mem_word_t;

  typedef struct packed {
    mem_addr_t addr;
    mem_word_t data;
  } host_write_t;

  function automatic int rr_ptr_width(input int n_cpus);
    return (n_cpus > 1) ? $clog2(n_cpus) : 1;
  endfunction

endpackage

// File: rtl/regex_instruction_memory_responder_arbiter.sv
// Combinational round-robin pick: first requester (not masked) at or after ptr, wrapping to 0.
// Zero latency; no backpressure of its own, the parent decides whether the grant is used.
module round_robin_arbiter #(
  parameter int N_CPUS       = 2,
  parameter int RR_PTR_WIDTH = 1
) (
  input  logic [N_CPUS-1:0]       req,
  input  logic [N_CPUS-1:0]       mask,
  input  logic [RR_PTR_WIDTH-1:0] ptr,
  output logic [N_CPUS-1:0]       grant,
  output logic [RR_PTR_WIDTH-1:0] idx,
  output logic                    any
);

  logic [N_CPUS-1:0] eligible;
  int                cand;

  assign eligible = req & ~mask;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 0; k < N_CPUS; k++) begin
      cand = (int'(ptr) + k) % N_CPUS;
      if (!any && eligible[cand]) begin
        grant[cand] = 1'b1;
        idx         = RR_PTR_WIDTH'(cand);
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regex_instruction_memory_responder.sv
// Regex program BRAM serving N cores: 1-cycle ready pulse, data broadcast the cycle after; host writes pre-empt fetches.
// REGEX_MEM_FETCH_STATS_EN adds a saturating fetch counter; otherwise fetch_count is tied to 0.
module regex_instruction_memory_responder
  import regex_memory_pkg::*;
#(
  parameter int N_CPUS            = 2,
  parameter int MEMORY_WIDTH      = DEF_MEMORY_WIDTH,
  parameter int MEMORY_ADDR_WIDTH = DEF_MEMORY_ADDR_WIDTH
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                host_write_valid,
  input  logic [MEMORY_ADDR_WIDTH-1:0]        host_write_addr,
  input  logic [MEMORY_WIDTH-1:0]             host_write_data,
  output logic                                host_write_ready,
  input  logic [N_CPUS-1:0]                   memory_valid,
  input  logic [N_CPUS*MEMORY_ADDR_WIDTH-1:0] memory_addr,
  output logic [N_CPUS-1:0]                   memory_ready,
  output logic [MEMORY_WIDTH-1:0]             memory_data,
  output logic [31:0]                         fetch_count
);

  localparam int RR_PTR_WIDTH = rr_ptr_width(N_CPUS);
  localparam int DEPTH        = 2 ** MEMORY_ADDR_WIDTH;

  logic [MEMORY_WIDTH-1:0]      mem [DEPTH];
  logic [RR_PTR_WIDTH-1:0]      rr_ptr;
  logic [N_CPUS-1:0]            last_grant;
  logic [N_CPUS-1:0]            arb_grant;
  logic [RR_PTR_WIDTH-1:0]      arb_idx;
  logic                         arb_any;
  logic                         wr_fire;
  logic                         rd_fire;
  logic [MEMORY_ADDR_WIDTH-1:0] rd_addr;
  logic [MEMORY_WIDTH-1:0]      rd_word;
  logic                         rd_pend;
  logic [RR_PTR_WIDTH-1:0]      next_ptr;

  // Host writes own the single BRAM port outright; a fetch waiting on them simply re-arbitrates.
  assign wr_fire = host_write_valid && host_write_ready && !reset;
  assign rd_fire = arb_any && !wr_fire && !reset;

  round_robin_arbiter #(
    .N_CPUS       (N_CPUS),
    .RR_PTR_WIDTH (RR_PTR_WIDTH)
  ) u_arb (
    .req   (memory_valid),
    .mask  (last_grant),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_comb begin
    rd_addr = '0;
    for (int i = 0; i < N_CPUS; i++) begin
      if (arb_grant[i]) begin
        rd_addr = memory_addr[i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
      end
    end
  end

  assign next_ptr = (arb_idx == RR_PTR_WIDTH'(N_CPUS - 1)) ? '0 : arb_idx + RR_PTR_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[host_write_addr] <= host_write_data;
    end else if (rd_fire) begin
      rd_word <= mem[rd_addr];
    end
  end

  // last_grant doubles as the ready pulse: the granted core's valid is still up next cycle and must be masked.
  always_ff @(posedge clk) begin
    if (reset) begin
      host_write_ready <= 1'b0;
      last_grant       <= '0;
      rr_ptr           <= '0;
      rd_pend          <= 1'b0;
      memory_data      <= '0;
    end else begin
      host_write_ready <= 1'b1;
      last_grant       <= rd_fire ? arb_grant : '0;
      rd_pend          <= rd_fire;
      if (rd_pend) begin
        memory_data <= rd_word;
      end
      if (rd_fire) begin
        rr_ptr <= next_ptr;
      end
    end
  end

  assign memory_ready = last_grant;

`ifdef REGEX_MEM_FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= '0;
    end else if (rd_fire && (fetch_count != 32'hFFFF_FFFF)) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_regex_instruction_memory_responder.sv
// Bench for regex_instruction_memory_responder: directed scenarios with literal expectations plus
// randomized core/host traffic compared every cycle against a cycle-level behavioural model.
module tb_regex_instruction_memory_responder;
  import regex_memory_pkg::*;

  localparam int N  = 2;
  localparam int AW = 11;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            hv;
  logic [AW-1:0]   ha;
  logic [DW-1:0]   hd;
  logic            hr;
  logic [N-1:0]    mv;
  logic [N*AW-1:0] ma;
  logic [N-1:0]    mr;
  logic [DW-1:0]   md;
  logic [31:0]     fc;

  logic            hv1;
  logic [AW-1:0]   ha1;
  logic [DW-1:0]   hd1;
  logic            hr1;
  logic [0:0]      mv1;
  logic [AW-1:0]   ma1;
  logic [0:0]      mr1;
  logic [DW-1:0]   md1;
  logic [31:0]     fc1;

  regex_instruction_memory_responder #(
    .N_CPUS(N), .MEMORY_WIDTH(DW), .MEMORY_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset),
    .host_write_valid(hv), .host_write_addr(ha), .host_write_data(hd), .host_write_ready(hr),
    .memory_valid(mv), .memory_addr(ma), .memory_ready(mr), .memory_data(md), .fetch_count(fc)
  );

  regex_instruction_memory_responder #(
    .N_CPUS(1), .MEMORY_WIDTH(DW), .MEMORY_ADDR_WIDTH(AW)
  ) dut1 (
    .clk(clk), .reset(reset),
    .host_write_valid(hv1), .host_write_addr(ha1), .host_write_data(hd1), .host_write_ready(hr1),
    .memory_valid(mv1), .memory_addr(ma1), .memory_ready(mr1), .memory_data(md1), .fetch_count(fc1)
  );

  // Behavioural model state: what each output must read during the cycle after the latest edge.
  mem_word_t      m_mem [2**AW];
  int             m_ptr;
  int             m_last;
  int             m_g;
  int             m_i;
  logic           m_hwr;
  logic [N-1:0]   m_ready;
  mem_word_t      m_data;
  logic           m_pend;
  mem_word_t      m_pend_val;
  logic [31:0]    m_count;
  logic           m_init = 1'b0;

  // Literal expectations set by the directed sequence for the edge that follows.
  logic           lit_rchk = 0, lit_dchk = 0, lit_hchk = 0, lit_cchk = 0;
  logic [N-1:0]   lit_rdy;
  mem_word_t      lit_data;
  logic           lit_hwr;
  logic [31:0]    lit_cnt;
  logic           lit1_rchk = 0, lit1_dchk = 0;
  logic [0:0]     lit1_rdy;
  mem_word_t      lit1_data;

  int checks = 0;
  int errors = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_init  = 1'b1;
        m_hwr   = 1'b0;
        m_ready = '0;
        m_data  = '0;
        m_pend  = 1'b0;
        m_ptr   = 0;
        m_last  = -1;
        m_count = 32'd0;
      end else begin
        if (m_pend) m_data = m_pend_val;
        m_pend  = 1'b0;
        m_ready = '0;
        m_g     = -1;
        if (hv && m_hwr) begin
          m_mem[ha] = hd;
          m_last    = -1;
        end else begin
          for (int k = 0; k < N; k++) begin
            m_i = (m_ptr + k) % N;
            if (m_g < 0 && mv[m_i] && m_i != m_last) m_g = m_i;
          end
          if (m_g >= 0) begin
            m_ready[m_g] = 1'b1;
            m_pend       = 1'b1;
            m_pend_val   = m_mem[ma[m_g*AW +: AW]];
            m_ptr        = (m_g + 1) % N;
            m_last       = m_g;
            if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
          end else begin
            m_last = -1;
          end
        end
        m_hwr = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (m_init) begin
        chk("ready", 32'(mr), 32'(m_ready));
        chk("data", 32'(md), 32'(m_data));
        chk("host_ready", 32'(hr), 32'(m_hwr));
`ifdef REGEX_MEM_FETCH_STATS_EN
        chk("fetch_count", fc, m_count);
`else
        chk("fetch_count", fc, 32'd0);
`endif
      end
      if (lit_rchk) chk("lit_ready", 32'(mr), 32'(lit_rdy));
      if (lit_dchk) chk("lit_data", 32'(md), 32'(lit_data));
      if (lit_hchk) chk("lit_host_ready", 32'(hr), 32'(lit_hwr));
      if (lit_cchk) chk("lit_fetch_count", fc, lit_cnt);
      if (lit1_rchk) chk("n1_ready", 32'(mr1), 32'(lit1_rdy));
      if (lit1_dchk) chk("n1_data", 32'(md1), 32'(lit1_data));
    end
  end

  task automatic nxt();
    @(negedge clk);
    lit_rchk  = 0;
    lit_dchk  = 0;
    lit_hchk  = 0;
    lit_cchk  = 0;
    lit1_rchk = 0;
    lit1_dchk = 0;
  endtask

  task automatic expect_rd(input logic [N-1:0] rdy, input logic dchk, input mem_word_t data);
    lit_rchk = 1;
    lit_rdy  = rdy;
    lit_dchk = dchk;
    lit_data = data;
  endtask

  logic [N-1:0] drop_q;
  logic [31:0]  exp_ten;

  initial begin
    reset = 1'b1;
    hv = 0; ha = '0; hd = '0; mv = '0; ma = '0;
    hv1 = 0; ha1 = '0; hd1 = '0; mv1 = '0; ma1 = '0;
    drop_q = '0;
`ifdef REGEX_MEM_FETCH_STATS_EN
    exp_ten = 32'd10;
`else
    exp_ten = 32'd0;
`endif
    nxt();
    // Reset state.
    expect_rd('0, 1, 16'h0000);
    lit_hchk = 1; lit_hwr = 1'b0; lit_cchk = 1; lit_cnt = 32'd0;
    nxt();
    reset = 1'b0;
    lit_hchk = 1; lit_hwr = 1'b1;
    nxt();

    for (int i = 0; i < 32; i++) begin
      hv = 1; ha = AW'(i); hd = 16'h5A00 ^ 16'(i * 257);
      nxt();
    end
    hv = 0;

    // Host load then single fetch.
    hv = 1; ha = 11'd5; hd = 16'hA0C3;
    nxt();
    hv = 0; mv = 2'b01; ma[0 +: AW] = 11'd5;
    expect_rd(2'b01, 0, '0);
    nxt();
    expect_rd(2'b00, 1, 16'hA0C3);
    nxt();
    mv = 2'b00;
    expect_rd(2'b00, 1, 16'hA0C3);
    nxt();

    reset = 1'b1;
    nxt();
    reset = 1'b0;
    nxt();

    // Simultaneous requests, pointer at 0.
    mv = 2'b11; ma[0 +: AW] = 11'd3; ma[AW +: AW] = 11'd7;
    expect_rd(2'b01, 0, '0);
    nxt();
    expect_rd(2'b10, 1, 16'h5903);
    nxt();
    mv = 2'b10;
    expect_rd(2'b00, 1, 16'h5D07);
    nxt();
    mv = 2'b00;
    expect_rd(2'b00, 1, 16'h5D07);
    nxt();

    // Host write and fetch of the same address in one cycle.
    hv = 1; ha = 11'd9; hd = 16'hBEEF; mv = 2'b10; ma[AW +: AW] = 11'd9;
    expect_rd(2'b00, 0, '0);
    nxt();
    hv = 0;
    expect_rd(2'b10, 0, '0);
    nxt();
    expect_rd(2'b00, 1, 16'hBEEF);
    nxt();
    mv = 2'b00;
    expect_rd(2'b00, 1, 16'hBEEF);
    nxt();

    // Reset the cycle after a grant, then re-request.
    mv = 2'b01; ma[0 +: AW] = 11'd5;
    expect_rd(2'b01, 0, '0);
    nxt();
    reset = 1'b1;
    expect_rd(2'b00, 1, 16'h0000);
    lit_hchk = 1; lit_hwr = 1'b0;
    nxt();
    reset = 1'b0;
    expect_rd(2'b01, 1, 16'h0000);
    lit_hchk = 1; lit_hwr = 1'b1;
    nxt();
    expect_rd(2'b00, 1, 16'hA0C3);
    nxt();
    mv = 2'b00;
    nxt();

    for (int k = 1; k <= 9; k++) begin
      mv = '0; mv[k % 2] = 1'b1; ma[(k % 2)*AW +: AW] = AW'(k);
      nxt();
      nxt();
      mv = '0;
      nxt();
    end
    lit_cchk = 1; lit_cnt = exp_ten;
    nxt();

    // Single-core instance: held valid yields alternate-cycle grants.
    hv1 = 1; ha1 = 11'd2; hd1 = 16'h1234;
    nxt();
    hv1 = 0; mv1 = 1'b1; ma1 = 11'd2;
    for (int j = 0; j < 8; j++) begin
      lit1_rchk = 1; lit1_rdy = (j % 2 == 0) ? 1'b1 : 1'b0;
      lit1_dchk = (j >= 1); lit1_data = 16'h1234;
      nxt();
    end
    mv1 = 1'b0;
    nxt();

    // Random traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (drop_q[i]) begin
          mv[i] = 1'b0;
          if ($urandom % 2 == 0) begin
            mv[i] = 1'b1;
            ma[i*AW +: AW] = AW'($urandom % 32);
          end
        end else if (!mv[i] && ($urandom % 3 == 0)) begin
          mv[i] = 1'b1;
          ma[i*AW +: AW] = AW'($urandom % 32);
        end
        drop_q[i] = mr[i];
      end
      hv    = ($urandom % 8 == 0);
      ha    = AW'($urandom % 32);
      hd    = DW'($urandom);
      reset = ($urandom % 400 == 0);
      nxt();
    end
    reset = 1'b0; hv = 0; mv = '0;
    nxt();
    nxt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
